// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense controller.
// Also holds helpers for coin-return decode and counter sizing.
package vend_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_DISP    = 3'd1;
   localparam state_t S_EJ2_ON  = 3'd2;
   localparam state_t S_EJ2_GAP = 3'd3;
   localparam state_t S_EJ1_ON  = 3'd4;
   localparam state_t S_EJ1_GAP = 3'd5;
   localparam state_t S_FAULT   = 3'd6;

   typedef struct packed {
      logic [1:0] n2;
      logic       n1;
   } entry_t;

   localparam logic [1:0] N2_RET22 = 2'd2;

   // ret22 means two 2-unit coins and masks ret1/ret2
   function automatic entry_t mk_entry(
      input logic r1,
      input logic r2,
      input logic r22
   );
      entry_t e;
      if (r22) begin
         e.n2 = N2_RET22;
         e.n1 = 1'b0;
      end else begin
         e.n2 = {1'b0, r2};
         e.n1 = r1;
      end
      return e;
   endfunction

   function automatic int max3(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vend_if.sv
// Sale handshake and mechanism bus between the coin FSM,
// the dispense controller and the vend mechanism.
interface vend_if;

   logic pour;
   logic ret1;
   logic ret2;
   logic ret22;
   logic disp_done;
   logic fault_clr;

   logic motor_on;
   logic eject1;
   logic eject2;
   logic vend_done;
   logic busy;
   logic inhibit;
   logic fault;
   logic overflow;

   modport master (
      output pour, ret1, ret2, ret22,
      output disp_done, fault_clr,
      input  motor_on, eject1, eject2,
      input  vend_done, busy, inhibit,
      input  fault, overflow
   );

   modport slave (
      input  pour, ret1, ret2, ret22,
      input  disp_done, fault_clr,
      output motor_on, eject1, eject2,
      output vend_done, busy, inhibit,
      output fault, overflow
   );

endinterface

// File: rtl/vend_txn_fifo.sv
// Pending-sale queue: sync FIFO with count and same-cycle push+pop.
// A push into a full queue is taken only if a pop frees a slot.
module vend_txn_fifo
   import vend_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNTW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  entry_t          din,
   output entry_t          dout,
   output logic            full,
   output logic            empty,
   output logic [CNTW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wp;
   logic [PW-1:0]   rp;
   logic            acc;
   logic            deq;

   function automatic logic [PW-1:0] inc(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (count == CNTW'(DEPTH));
   assign empty = (count == '0);
   assign acc   = push && (!full || pop);
   assign deq   = pop && !empty;
   assign dout  = mem[rp];

   always_ff @(posedge clk) begin
      if (acc) begin
         mem[wp] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (acc) begin
            wp <= inc(wp);
         end
         if (deq) begin
            rp <= inc(rp);
         end
         count <= count + CNTW'(acc) - CNTW'(deq);
      end
   end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend sequencer: queues decided sales, runs the motor until ack,
// then pulses the 2-unit and 1-unit hoppers once per change coin.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int DEPTH       = 2,
   parameter int TIMEOUT     = 64,
   parameter int EJECT_PULSE = 2,
   parameter int EJECT_GAP   = 4
) (
   input logic clk,
   input logic rst,
   vend_if.slave bus
);

   localparam int MX   = max3(TIMEOUT, EJECT_PULSE, EJECT_GAP);
   localparam int CW   = $clog2(MX + 1);
   localparam int CNTW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] PUL_LAST = CW'(EJECT_PULSE - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(EJECT_GAP - 1);

   state_t          st;
   state_t          nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [1:0]      n2;
   logic [1:0]      n2_nxt;
   logic            n1;
   logic            n1_nxt;
   logic            done;

   logic            cap_v;
   entry_t          cap_e;
   entry_t          head;
   logic            qfull;
   logic            qempty;
   logic [CNTW-1:0] qcnt;
   logic [CNTW-1:0] qcnt_nxt;
   logic            qacc;
   logic            pop;

   logic motor_q;
   logic ej1_q;
   logic ej2_q;
   logic vd_q;
   logic busy_q;
   logic inh_q;
   logic flt_q;
   logic ovf_q;

   vend_txn_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap_v),
      .pop   (pop),
      .din   (cap_e),
      .dout  (head),
      .full  (qfull),
      .empty (qempty),
      .count (qcnt)
   );

   assign pop      = (st == S_IDLE) && !qempty;
   assign qacc     = cap_v && (!qfull || pop);
   assign qcnt_nxt = qcnt + CNTW'(qacc) - CNTW'(pop);

   always_comb begin
      nxt     = st;
      cnt_nxt = cnt;
      n2_nxt  = n2;
      n1_nxt  = n1;
      done    = 1'b0;
      unique case (1'b1)
         (st == S_IDLE): begin
            if (pop) begin
               nxt     = S_DISP;
               cnt_nxt = '0;
               n2_nxt  = head.n2;
               n1_nxt  = head.n1;
            end
         end
         (st == S_DISP): begin
            // an ack on the last allowed cycle beats the timeout
            if (bus.disp_done) begin
               cnt_nxt = '0;
               if (n2 != 2'd0) begin
                  nxt = S_EJ2_ON;
               end else if (n1) begin
                  nxt = S_EJ1_ON;
               end else begin
                  nxt  = S_IDLE;
                  done = 1'b1;
               end
            end else if (cnt == TMO_LAST) begin
               nxt     = S_FAULT;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         (st == S_EJ2_ON): begin
            if (cnt == PUL_LAST) begin
               nxt     = S_EJ2_GAP;
               cnt_nxt = '0;
               n2_nxt  = n2 - 2'd1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         (st == S_EJ2_GAP): begin
            if (cnt == GAP_LAST) begin
               cnt_nxt = '0;
               if (n2 != 2'd0) begin
                  nxt = S_EJ2_ON;
               end else if (n1) begin
                  nxt = S_EJ1_ON;
               end else begin
                  nxt  = S_IDLE;
                  done = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         (st == S_EJ1_ON): begin
            if (cnt == PUL_LAST) begin
               nxt     = S_EJ1_GAP;
               cnt_nxt = '0;
               n1_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         (st == S_EJ1_GAP): begin
            if (cnt == GAP_LAST) begin
               cnt_nxt = '0;
               nxt     = S_IDLE;
               done    = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         (st == S_FAULT): begin
            if (bus.fault_clr) begin
               nxt = S_IDLE;
            end
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   // outputs are registered from the next state so they track st exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= S_IDLE;
         cnt     <= '0;
         n2      <= '0;
         n1      <= 1'b0;
         cap_v   <= 1'b0;
         cap_e   <= '0;
         motor_q <= 1'b0;
         ej1_q   <= 1'b0;
         ej2_q   <= 1'b0;
         vd_q    <= 1'b0;
         busy_q  <= 1'b0;
         inh_q   <= 1'b0;
         flt_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         st      <= nxt;
         cnt     <= cnt_nxt;
         n2      <= n2_nxt;
         n1      <= n1_nxt;
         cap_v   <= bus.pour;
         cap_e   <= mk_entry(bus.ret1, bus.ret2, bus.ret22);
         motor_q <= (nxt == S_DISP);
         ej1_q   <= (nxt == S_EJ1_ON);
         ej2_q   <= (nxt == S_EJ2_ON);
         vd_q    <= done;
         busy_q  <= (nxt != S_IDLE) || (qcnt_nxt != '0);
         inh_q   <= (qcnt_nxt == CNTW'(DEPTH)) || (nxt == S_FAULT);
         flt_q   <= (nxt == S_FAULT);
         ovf_q   <= ovf_q || (cap_v && qfull && !pop);
      end
   end

   assign bus.motor_on  = motor_q;
   assign bus.eject1    = ej1_q;
   assign bus.eject2    = ej2_q;
   assign bus.vend_done = vd_q;
   assign bus.busy      = busy_q;
   assign bus.inhibit   = inh_q;
   assign bus.fault     = flt_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with DEPTH=2, TIMEOUT=64,
// EJECT_PULSE=2, EJECT_GAP=4.
module tb_vend_dispense_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vend_if bus ();

   vend_dispense_ctrl #(
      .DEPTH       (2),
      .TIMEOUT     (64),
      .EJECT_PULSE (2),
      .EJECT_GAP   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_run  = 0;
   int n_fail = 0;

   int m_motor = 0;
   int m_e1    = 0;
   int m_e2    = 0;
   int m_r2    = 0;
   int m_vd    = 0;
   int m_both  = 0;
   logic pe2   = 1'b0;

   always @(negedge clk) begin
      m_motor += int'(bus.motor_on);
      m_e1    += int'(bus.eject1);
      m_e2    += int'(bus.eject2);
      m_vd    += int'(bus.vend_done);
      if (bus.eject2 && !pe2) m_r2++;
      if (bus.eject1 && bus.eject2) m_both++;
      pe2 = bus.eject2;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {bus.motor_on, bus.eject1, bus.eject2,
              bus.vend_done, bus.busy, bus.inhibit,
              bus.fault, bus.overflow};
   endfunction

   task automatic pour_sale(
      input logic r1,
      input logic r2,
      input logic r22
   );
      bus.pour  = 1'b1;
      bus.ret1  = r1;
      bus.ret2  = r2;
      bus.ret22 = r22;
      step();
      bus.pour  = 1'b0;
      bus.ret1  = 1'b0;
      bus.ret2  = 1'b0;
      bus.ret22 = 1'b0;
   endtask

   task automatic wait_motor(input string tag);
      int k = 0;
      while (bus.motor_on !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk(tag, 32'(bus.motor_on), 32'd1);
   endtask

   task automatic done_now;
      bus.disp_done = 1'b1;
      step();
      bus.disp_done = 1'b0;
   endtask

   task automatic wait_vend(input string tag);
      int k = 0;
      while (bus.vend_done !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      chk(tag, 32'(bus.vend_done), 32'd1);
      step();
   endtask

   initial begin
      int s_mo, s_e1, s_e2, s_r2, s_vd;
      int hi, k;

      bus.pour      = 1'b0;
      bus.ret1      = 1'b0;
      bus.ret2      = 1'b0;
      bus.ret22     = 1'b0;
      bus.disp_done = 1'b0;
      bus.fault_clr = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("reset_outs", 32'(outs()), 32'h0);
      rst = 1'b0;
      step();
      chk("idle_outs", 32'(outs()), 32'h0);

      // 1: plain sale, 5-cycle dispense
      s_mo = m_motor; s_e1 = m_e1; s_e2 = m_e2; s_vd = m_vd;
      pour_sale(1'b0, 1'b0, 1'b0);
      chk("t1_motor_k0", 32'(bus.motor_on), 32'd0);
      step();
      chk("t1_motor_k1", 32'(bus.motor_on), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      step();
      chk("t1_motor_k2", 32'(bus.motor_on), 32'd1);
      repeat (4) step();
      chk("t1_motor_k6", 32'(bus.motor_on), 32'd1);
      done_now();
      chk("t1_motor_drop", 32'(bus.motor_on), 32'd0);
      chk("t1_vend", 32'(bus.vend_done), 32'd1);
      step();
      chk("t1_vend_1cyc", 32'(bus.vend_done), 32'd0);
      chk("t1_idle", 32'(bus.busy), 32'd0);
      chk("t1_motor_cyc", 32'(m_motor - s_mo), 32'd5);
      chk("t1_no_eject", 32'((m_e1 - s_e1) + (m_e2 - s_e2)), 32'd0);
      chk("t1_vend_cnt", 32'(m_vd - s_vd), 32'd1);

      // 2: ret1+ret2 -> one 2-unit then one 1-unit coin
      s_e1 = m_e1; s_e2 = m_e2;
      pour_sale(1'b1, 1'b1, 1'b0);
      step();
      step();
      repeat (4) step();
      done_now();
      chk("t2_ej2_a", 32'({bus.motor_on, bus.eject2}), 32'b01);
      step();
      chk("t2_ej2_b", 32'(bus.eject2), 32'd1);
      step();
      chk("t2_ej2_off", 32'(bus.eject2), 32'd0);
      repeat (3) step();
      chk("t2_gap2_end", 32'({bus.eject1, bus.eject2}), 32'b00);
      step();
      chk("t2_ej1_a", 32'(bus.eject1), 32'd1);
      step();
      chk("t2_ej1_b", 32'(bus.eject1), 32'd1);
      step();
      chk("t2_ej1_off", 32'(bus.eject1), 32'd0);
      repeat (3) step();
      chk("t2_gap1_end", 32'(bus.vend_done), 32'd0);
      step();
      chk("t2_vend", 32'(bus.vend_done), 32'd1);
      step();
      chk("t2_idle", 32'(bus.busy), 32'd0);
      chk("t2_e2_cyc", 32'(m_e2 - s_e2), 32'd2);
      chk("t2_e1_cyc", 32'(m_e1 - s_e1), 32'd2);

      // 3: ret22 overrides ret1
      s_e1 = m_e1; s_e2 = m_e2; s_r2 = m_r2;
      pour_sale(1'b1, 1'b0, 1'b1);
      wait_motor("t3_motor");
      done_now();
      wait_vend("t3_vend");
      chk("t3_e2_pulses", 32'(m_r2 - s_r2), 32'd2);
      chk("t3_e2_cyc", 32'(m_e2 - s_e2), 32'd4);
      chk("t3_no_e1", 32'(m_e1 - s_e1), 32'd0);

      // ret without pour, disp_done while idle
      bus.ret1 = 1'b1;
      bus.ret2 = 1'b1;
      step();
      step();
      bus.ret1 = 1'b0;
      bus.ret2 = 1'b0;
      step();
      chk("ret_no_pour", 32'(bus.busy), 32'd0);
      done_now();
      chk("done_idle_vd", 32'(bus.vend_done), 32'd0);
      step();
      chk("done_idle", 32'({bus.busy, bus.motor_on}), 32'b00);

      // 4: three pours during a dispense overflow the queue
      s_vd = m_vd;
      pour_sale(1'b0, 1'b0, 1'b0);
      wait_motor("t4_motor_a");
      bus.pour = 1'b1;
      step();
      step();
      step();
      chk("t4_inhibit", 32'(bus.inhibit), 32'd1);
      chk("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
      bus.pour = 1'b0;
      step();
      chk("t4_overflow", 32'(bus.overflow), 32'd1);
      chk("t4_inh_hold", 32'(bus.inhibit), 32'd1);
      done_now();
      wait_vend("t4_vend_a");
      wait_motor("t4_motor_b");
      chk("t4_inh_drop", 32'(bus.inhibit), 32'd0);
      done_now();
      wait_vend("t4_vend_b");
      wait_motor("t4_motor_c");
      done_now();
      wait_vend("t4_vend_c");
      step();
      chk("t4_empty", 32'(bus.busy), 32'd0);
      chk("t4_vend_cnt", 32'(m_vd - s_vd), 32'd3);
      chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

      // 5: motor timeout -> FAULT, queued sale served after clear
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_ovf_clr", 32'(bus.overflow), 32'd0);
      pour_sale(1'b0, 1'b0, 1'b0);
      wait_motor("t5_motor");
      s_vd = m_vd;
      hi = 0;
      k = 0;
      while (bus.motor_on === 1'b1 && k < 100) begin
         hi++;
         bus.pour = (k == 0);
         step();
         k++;
      end
      bus.pour = 1'b0;
      chk("t5_motor_cyc", 32'(hi), 32'd64);
      chk("t5_fault", 32'(outs()), 32'b0000_1110);
      repeat (3) step();
      chk("t5_fault_hold", 32'(bus.fault), 32'd1);
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
      chk("t5_cleared", 32'({bus.fault, bus.inhibit}), 32'b00);
      wait_motor("t5_motor_q");
      done_now();
      wait_vend("t5_vend_q");
      chk("t5_vend_cnt", 32'(m_vd - s_vd), 32'd1);

      // disp_done on the last allowed cycle wins over timeout
      pour_sale(1'b0, 1'b0, 1'b0);
      wait_motor("tb_motor");
      repeat (63) step();
      chk("tb_last_cyc", 32'({bus.motor_on, bus.fault}), 32'b10);
      done_now();
      chk("tb_no_fault", 32'(bus.fault), 32'd0);
      chk("tb_vend", 32'(bus.vend_done), 32'd1);
      step();

      // 6: reset in the middle of EJ2_ON
      pour_sale(1'b0, 1'b1, 1'b0);
      wait_motor("t6_motor");
      pour_sale(1'b0, 1'b0, 1'b0);
      step();
      done_now();
      chk("t6_ej2", 32'({bus.eject2, bus.busy}), 32'b11);
      rst = 1'b1;
      step();
      chk("t6_rst_outs", 32'(outs()), 32'h0);
      rst = 1'b0;
      repeat (5) step();
      chk("t6_after", 32'({bus.motor_on, bus.busy}), 32'b00);

      chk("never_both_ej", 32'(m_both), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
